// File: rtl/packet_builder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | packet_builder_if : payload request + 32-bit word stream bundle       |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
interface packet_builder_if #(
  parameter int MAX_BYTES = 37
);
  logic [0:MAX_BYTES*8-1] pktData;
  logic [5:0]             pktLen;
  logic [15:0]            pktStream;
  logic                   pktIn_val;
  logic                   pktIn_ready;
  logic [31:0]            dataOut;
  logic                   dataOut_val;
  logic                   dataOut_ready;
  logic                   dataOut_last;
  logic                   lenErr;

  // Packet source / link consumer side
  modport master (
    output pktData, pktLen, pktStream, pktIn_val, dataOut_ready,
    input  pktIn_ready, dataOut, dataOut_val, dataOut_last, lenErr
  );

  // Builder side
  modport slave (
    input  pktData, pktLen, pktStream, pktIn_val, dataOut_ready,
    output pktIn_ready, dataOut, dataOut_val, dataOut_last, lenErr
  );
endinterface
`default_nettype wire

// File: rtl/packet_builder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | packet_builder : stamps per-stream sequence numbers and serialises a  |
// | payload as header / sequence / data words on a valid-ready-last link. |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module packet_builder #(
  parameter int MAX_BYTES   = 37,
  parameter int NUM_STREAMS = 32
) (
  input  logic             clk,
  input  logic             reset_b,
  packet_builder_if.slave  bus
);

  localparam int IDX_W     = $clog2(NUM_STREAMS);
  localparam int MAX_WORDS = (MAX_BYTES + 3) / 4;
  localparam int NW_W      = $clog2(MAX_WORDS + 1);
  // one spare word so the look-ahead past the final word stays in range
  localparam int PAD_BYTES = MAX_WORDS * 4 + 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_HDR  = 2'd1,
    SEND_SEQ  = 2'd2,
    SEND_DATA = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [0:MAX_BYTES*8-1] data_q, data_d;
  logic [5:0]             len_q, len_d;
  logic [31:0]            seq_q, seq_d;
  logic [NW_W-1:0]        widx_q, widx_d;
  logic [31:0]            dout_q, dout_d;
  logic                   val_q, val_d;
  logic                   last_q, last_d;
  logic                   len_err_q, len_err_d;
  logic [31:0]            cnt_q [NUM_STREAMS];
  logic [31:0]            cnt_d [NUM_STREAMS];

  logic [IDX_W-1:0]       w_cnt_idx;
  logic [31:0]            w_new_seq;
  logic                   w_len_ok;
  logic                   w_handshake;
  logic [6:0]             w_nwords_full;
  logic [NW_W-1:0]        w_nwords;
  logic [NW_W-1:0]        w_word_sel;
  logic [NW_W+4:0]        w_word_off;
  logic [31:0]            w_word;
  logic [0:PAD_BYTES*8-1] w_pad;

  // Bytes past the packet length are zeroed so the tail word is clean.
  for (genvar k = 0; k < PAD_BYTES; k++) begin : g_pad
    if (k < MAX_BYTES) begin : g_live
      assign w_pad[8*k +: 8] = (len_q > 6'(k)) ? data_q[8*k +: 8] : 8'h00;
    end else begin : g_zero
      assign w_pad[8*k +: 8] = 8'h00;
    end
  end

  assign w_cnt_idx     = bus.pktStream[IDX_W-1:0];
  assign w_new_seq     = cnt_q[w_cnt_idx] + 32'd1;
  assign w_len_ok      = (bus.pktLen != 6'd0) && (bus.pktLen <= 6'(MAX_BYTES));
  assign w_handshake   = val_q & bus.dataOut_ready;
  assign w_nwords_full = ({1'b0, len_q} + 7'd3) >> 2;
  assign w_nwords      = w_nwords_full[NW_W-1:0];
  assign w_word_sel    = (state_q == SEND_SEQ) ? '0 : widx_q + NW_W'(1);
  assign w_word_off    = {w_word_sel, 5'b00000};
  assign w_word        = w_pad[w_word_off +: 32];

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    seq_d     = seq_q;
    widx_d    = widx_q;
    dout_d    = dout_q;
    val_d     = val_q;
    last_d    = last_q;
    len_err_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.pktIn_val) begin
          if (w_len_ok) begin
            data_d             = bus.pktData;
            len_d              = bus.pktLen;
            seq_d              = w_new_seq;
            cnt_d[w_cnt_idx]   = w_new_seq;
            widx_d             = '0;
            dout_d             = {{10'd0, bus.pktLen} + 16'd8, bus.pktStream};
            val_d              = 1'b1;
            last_d             = 1'b0;
            state_d            = SEND_HDR;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      SEND_HDR: begin
        if (w_handshake) begin
          dout_d  = seq_q;
          state_d = SEND_SEQ;
        end
      end
      SEND_SEQ: begin
        if (w_handshake) begin
          dout_d  = w_word;
          widx_d  = '0;
          last_d  = (w_nwords == NW_W'(1));
          state_d = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (w_handshake) begin
          if (last_q) begin
            dout_d  = '0;
            val_d   = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            dout_d = w_word;
            widx_d = w_word_sel;
            last_d = ((w_word_sel + NW_W'(1)) == w_nwords);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      seq_q     <= '0;
      widx_q    <= '0;
      dout_q    <= '0;
      val_q     <= 1'b0;
      last_q    <= 1'b0;
      len_err_q <= 1'b0;
      cnt_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
      widx_q    <= widx_d;
      dout_q    <= dout_d;
      val_q     <= val_d;
      last_q    <= last_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pktIn_ready  = (state_q == IDLE);
  assign bus.dataOut      = dout_q;
  assign bus.dataOut_val  = val_q;
  assign bus.dataOut_last = last_q;
  assign bus.lenErr       = len_err_q;

endmodule
`default_nettype wire
